// File: rtl/trdb_pkg.sv
// Shared trace-debugger constants. The branch-map size is used by the map
// itself, the packet-format selector and the packet emitter.
package trdb_pkg;

   localparam int unsigned BMAP_LEN   = 31;
   localparam int unsigned BMAP_CNT_W = $clog2(BMAP_LEN + 1);

endpackage : trdb_pkg

// File: rtl/trdb_branch_map.sv
// Branch map: collects taken/not-taken bits of retired conditional branches.
// Optional sticky overflow reporting is enabled with TRDB_BMAP_OVERFLOW_CHK_EN.
module trdb_branch_map
   import trdb_pkg::*;
#(
   parameter int unsigned MAP_LEN = BMAP_LEN,
   parameter int unsigned CNT_W   = $clog2(MAP_LEN + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               valid_i,
   input  logic               branch_taken_i,
   input  logic               flush_i,
   output logic [MAP_LEN-1:0] map_o,
   output logic [CNT_W-1:0]   branches_o,
   output logic               is_empty_o,
   output logic               is_full_o,
   output logic               nc_is_empty_o,
   output logic               overflow_o
);

   logic [MAP_LEN-1:0] map_q, map_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [MAP_LEN-1:0] wr_sel;
   logic               full;

   assign full = (cnt_q == CNT_W'(MAP_LEN));

   // One-hot write position: the slot just above the current count
   for (genvar gi = 0; gi < MAP_LEN; gi++) begin : g_wr_sel
      assign wr_sel[gi] = (cnt_q == CNT_W'(gi));
   end

   always_comb begin
      map_d = map_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         // Flush first, then insert, so a coincident branch lands in bit 0
         map_d = '0;
         cnt_d = '0;
         if (valid_i) begin
            map_d[0] = ~branch_taken_i;
            cnt_d    = CNT_W'(1);
         end
      end else if (valid_i && !full) begin
         map_d = map_q | (wr_sel & {MAP_LEN{~branch_taken_i}});
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         map_q <= '0;
         cnt_q <= '0;
      end else begin
         map_q <= map_d;
         cnt_q <= cnt_d;
      end
   end

   assign map_o         = map_q;
   assign branches_o    = cnt_q;
   assign is_empty_o    = (cnt_q == '0);
   assign is_full_o     = full;
   assign nc_is_empty_o = flush_i ? ~valid_i : (is_empty_o & ~valid_i);

`ifdef TRDB_BMAP_OVERFLOW_CHK_EN
   logic ovf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q <= 1'b0;
      end else if (valid_i && full && !flush_i) begin
         ovf_q <= 1'b1;
      end
   end

   assign overflow_o = ovf_q;

   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(valid_i && full && !flush_i))
      else $warning("branch map overflow: branch dropped");
`else
   assign overflow_o = 1'b0;
`endif

endmodule : trdb_branch_map

// File: tb/tb_trdb_branch_map.sv
// Self-checking bench for trdb_branch_map: directed scenarios followed by
// random traffic, all compared against a queue-based model of the branch list.
module tb_trdb_branch_map;

   localparam int L = 31;

   logic          clk;
   logic          rst_n;
   logic          v, t, f;
   logic [L-1:0]  map_o;
   logic [4:0]    branches_o;
   logic          is_empty_o, is_full_o, nc_is_empty_o, overflow_o;

   int            n_vec;
   int            n_err;
   bit            q[$];   // model: not-taken bits, oldest first
   bit            ovf_m;

   trdb_branch_map dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .valid_i        (v),
      .branch_taken_i (t),
      .flush_i        (f),
      .map_o          (map_o),
      .branches_o     (branches_o),
      .is_empty_o     (is_empty_o),
      .is_full_o      (is_full_o),
      .nc_is_empty_o  (nc_is_empty_o),
      .overflow_o     (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_map();
      logic [31:0] m;
      m = '0;
      for (int k = 0; k < q.size(); k++) m = m + (32'(q[k]) << k);
      return m;
   endfunction

   function automatic logic exp_ovf();
`ifdef TRDB_BMAP_OVERFLOW_CHK_EN
      return ovf_m;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk_all(input string tag);
      chk({tag, "_map"},   map_o,      model_map());
      chk({tag, "_cnt"},   branches_o, q.size());
      chk({tag, "_empty"}, is_empty_o, q.size() == 0);
      chk({tag, "_full"},  is_full_o,  q.size() == L);
      chk({tag, "_ovf"},   overflow_o, exp_ovf());
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the next.
   task automatic step(input logic vv, input logic tt, input logic ff);
      int ns;
      v = vv; t = tt; f = ff;
      #1;
      ns = ff ? (vv ? 1 : 0) : ((vv && q.size() < L) ? q.size() + 1 : q.size());
      chk("pre_map", map_o, model_map());
      chk("pre_cnt", branches_o, q.size());
      chk("nc_empty", nc_is_empty_o, ns == 0);
      @(posedge clk); #1;
      if (ff) begin
         q.delete();
         if (vv) q.push_back(~tt);
      end else if (vv) begin
         if (q.size() < L) q.push_back(~tt);
         else ovf_m = 1'b1;
      end
      $display("step v=%0b t=%0b f=%0b -> cnt=%0d map=%08h", vv, tt, ff, branches_o, map_o);
      chk_all("post");
   endtask

   initial begin
      n_vec = 0; n_err = 0; ovf_m = 1'b0;
      v = 0; t = 0; f = 0; rst_n = 1'b0;
      #3;
      chk_all("reset");
      chk("reset_nc", nc_is_empty_o, 1'b1);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // T, NT, T
      step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
      chk("t1_cnt", branches_o, 3);
      chk("t1_map", map_o[2:0], 3'b010);
      chk("t1_empty", is_empty_o, 1'b0);
      step(0, 0, 1);

      // 31 not-taken branches fill the map
      for (int i = 0; i < L; i++) step(1, 0, 0);
      chk("t2_cnt", branches_o, 31);
      chk("t2_map", map_o, 31'h7FFF_FFFF);
      chk("t2_full", is_full_o, 1'b1);

      // Flush with a coincident taken branch
      v = 1; t = 1; f = 1; #1;
      chk("t3_seen_cnt", branches_o, 31);
      chk("t3_seen_map", map_o, 31'h7FFF_FFFF);
      chk("t3_nc", nc_is_empty_o, 1'b0);
      step(1, 1, 1);
      chk("t3_cnt", branches_o, 1);
      chk("t3_map", map_o, 0);

      // Refill, then a branch while full without flush
      for (int i = 0; i < L - 1; i++) step(1, 0, 0);
      step(1, 1, 0);
      chk("t4_cnt", branches_o, 31);
      chk("t4_map", map_o, 31'h7FFF_FFFE);
      step(0, 0, 1);
      step(0, 0, 0);

      // 5 branches, then a plain flush
      for (int i = 0; i < 5; i++) step(1, i[0], 0);
      v = 0; t = 0; f = 1; #1;
      chk("t5_nc", nc_is_empty_o, 1'b1);
      step(0, 0, 1);
      chk("t5_cnt", branches_o, 0);
      chk("t5_map", map_o, 0);
      chk("t5_empty", is_empty_o, 1'b1);

      // Asynchronous reset in the middle of accumulation
      for (int i = 0; i < 12; i++) step(1, 0, 0);
      #2 rst_n = 1'b0; v = 0; f = 0;
      #1;
      q.delete(); ovf_m = 1'b0;
      chk_all("arst");
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      step(1, 0, 0);
      chk("t6_cnt", branches_o, 1);
      chk("t6_map", map_o, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 24) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_trdb_branch_map
